// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// memory-freeze FSM states and the result-source encoding of a load.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    FAULT
  } hz_state_e;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one E-stage source operand. A younger producer in M
// wins over an older one in W; x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rsE,
  input  logic [4:0] rdM,
  input  logic       regwriteM,
  input  logic [4:0] rdW,
  input  logic       regwriteW,
  output fwd_sel_e   sel
);

  // Priority compare: M match first, then W, else register file.
  always_comb begin
    sel = FWD_RF;
    if (regwriteM && (rdM != 5'd0) && (rdM == rsE)) begin
      sel = FWD_M;
    end else if (regwriteW && (rdW != 5'd0) && (rdW == rsE)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage RV32 core.
// Drives stall/flush of the F/D/E/M/W registers, E-stage forwarding selects,
// and a freeze FSM for multi-cycle data-memory accesses with timeout trap.
// Build option HAZARD_FWD_EN: when defined, operands are forwarded and only
// load-use stalls; when undefined, forwarding is off and any RAW dependency
// on E or M stalls D (W is covered by the write-through register file).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic             regwriteE,
  input  logic [1:0]       result_srcE,
  input  logic             pc_srcE,
  input  logic [4:0]       rdM,
  input  logic             regwriteM,
  input  logic             memwriteM,
  input  logic [1:0]       result_srcM,
  input  logic             dmem_ready,
  input  logic [4:0]       rdW,
  input  logic             regwriteW,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forward_aE,
  output logic [1:0]       forward_bE,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_count
);

  hz_state_e        state_reg, state_next;
  logic [31:0]      wait_cnt_reg, wait_cnt_next;
  logic             mem_fault_reg;
  logic [CNT_W-1:0] stall_count_reg;

  logic             mem_req;
  logic             freeze;
  logic             hazard;
  logic             timeout_hit;
  logic [1:0]       fwd_a, fwd_b;
  logic             d_uses_rdE;

  assign mem_req     = memwriteM | (result_srcM == RESULT_LOAD);
  assign freeze      = (state_reg == FAULT) | (mem_req & ~dmem_ready);
  assign d_uses_rdE  = (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
  // Fires on the WAIT cycle that brings the waiting count up to MEM_TIMEOUT.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_reg == 32'(MEM_TIMEOUT - 1));

`ifdef HAZARD_FWD_EN
  logic [4:0] rs_sel  [2];
  fwd_sel_e   fwd_sel [2];
  logic       fwd_unused;

  assign rs_sel[0] = rs1E;
  assign rs_sel[1] = rs2E;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    hazard_fwd_sel u_sel (
      .rsE       (rs_sel[gi]),
      .rdM       (rdM),
      .regwriteM (regwriteM),
      .rdW       (rdW),
      .regwriteW (regwriteW),
      .sel       (fwd_sel[gi])
    );
  end

  assign fwd_a      = fwd_sel[0];
  assign fwd_b      = fwd_sel[1];
  // Only a load in E cannot be forwarded in time; rs2D compared conservatively.
  assign hazard     = (result_srcE == RESULT_LOAD) && d_uses_rdE;
  assign fwd_unused = regwriteE;
`else
  logic fwd_unused;

  assign fwd_a      = FWD_RF;
  assign fwd_b      = FWD_RF;
  // No bypass network: any pending E or M write to a D source must drain.
  assign hazard     = ((result_srcE == RESULT_LOAD) && d_uses_rdE)
                    || (regwriteE && d_uses_rdE)
                    || (regwriteM && (rdM != 5'd0) && ((rdM == rs1D) || (rdM == rs2D)));
  assign fwd_unused = ^{rs1E, rs2E, rdW, regwriteW};
`endif

  // Freeze FSM next state and waiting-cycle counter.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        wait_cnt_next = 32'd0;
        if (mem_req && !dmem_ready) state_next = WAIT;
      end
      WAIT: begin
        if (dmem_ready) begin
          state_next    = RUN;
          wait_cnt_next = 32'd0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 32'd1;
          if (timeout_hit) state_next = FAULT;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = 32'd0;
      end
    endcase
  end

  // Pipeline control outputs: reset, then freeze > redirect > data hazard.
  always_comb begin
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushW     = 1'b0;
    forward_aE = FWD_RF;
    forward_bE = FWD_RF;
    if (rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushW = 1'b1;
    end else begin
      forward_aE = fwd_a;
      forward_bE = fwd_b;
      if (freeze) begin
        // E stays stalled, so a pending redirect survives the freeze.
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (pc_srcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (hazard) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // State register, sticky fault flag and wrapping stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 32'd0;
      mem_fault_reg   <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      mem_fault_reg <= mem_fault_reg | (state_next == FAULT);
      if (stallF) stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign mem_fault   = mem_fault_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// cycles against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 4;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic regwriteE, pc_srcE, regwriteM, memwriteM, dmem_ready, regwriteW;
  logic [1:0] result_srcE, result_srcM;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_fault;
  logic [1:0] forward_aE, forward_bE;
  logic [CNT_W-1:0] stall_count;
  logic [10:0] dut_out;

  int checks = 0;
  int errors = 0;

  // Reference model state: fault trapped, access outstanding, waiting cycles.
  bit m_fault;
  bit m_waiting;
  int m_wait;
  int m_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .regwriteE(regwriteE), .result_srcE(result_srcE), .pc_srcE(pc_srcE),
    .rdM(rdM), .regwriteM(regwriteM), .memwriteM(memwriteM),
    .result_srcM(result_srcM), .dmem_ready(dmem_ready),
    .rdW(rdW), .regwriteW(regwriteW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forward_aE(forward_aE), .forward_bE(forward_bE),
    .mem_fault(mem_fault), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign dut_out = {stallF, stallD, stallE, stallM, flushD, flushE, flushW,
                    forward_aE, forward_bE};

  function automatic logic [1:0] pick(input logic [4:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mem_req_now();
    return memwriteM || (result_srcM == 2'b01);
  endfunction

  // Expected {stalls[4], flushD/E/W, fwdA, fwdB} for the current inputs.
  function automatic logic [10:0] model_out();
    logic [1:0] fa, fb;
    bit ldu, raw, hz;
    if (rst) return 11'b0000_111_0000;
    fa = FWD ? pick(rs1E) : 2'b00;
    fb = FWD ? pick(rs2E) : 2'b00;
    ldu = (result_srcE == 2'b01) && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    raw = ldu || (regwriteE && rdE != 0 && (rdE == rs1D || rdE == rs2D))
              || (regwriteM && rdM != 0 && (rdM == rs1D || rdM == rs2D));
    hz = FWD ? ldu : raw;
    if (m_fault || (mem_req_now() && !dmem_ready)) return {7'b1111_001, fa, fb};
    if (pc_srcE) return {7'b0000_110, fa, fb};
    if (hz) return {7'b1100_010, fa, fb};
    return {7'b0000_000, fa, fb};
  endfunction

  // Advance one clock; the model takes the same edge using pre-edge inputs.
  task automatic step();
    logic [10:0] e;
    bit req;
    e   = model_out();
    req = mem_req_now();
    @(posedge clk);
    if (rst) begin
      m_fault = 0; m_waiting = 0; m_wait = 0; m_cnt = 0;
    end else begin
      if (e[10]) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (!m_fault) begin
        if (m_waiting) begin
          if (dmem_ready) m_waiting = 0;
          else begin
            m_wait++;
            if (TMO != 0 && m_wait == TMO) m_fault = 1;
          end
        end else if (req && !dmem_ready) begin
          m_waiting = 1;
          m_wait    = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    regwriteE = 0; pc_srcE = 0; regwriteM = 0; memwriteM = 0; regwriteW = 0;
    result_srcE = 0; result_srcM = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; memwriteM = 1; dmem_ready = 0; pc_srcE = 1;
    regwriteM = 1; rdM = 5; rs1E = 5;
    @(negedge clk);
    checks++;
    if (dut_out !== 11'b0000_111_0000) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", dut_out, 11'b0000_111_0000);
    end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (mem_fault !== 1'b0 || stall_count !== '0) begin
      errors++; $display("FAIL reset_regs: mem_fault=%b stall_count=%0d want 0/0", mem_fault, stall_count);
    end
    $display("test_reset: outputs=%b", dut_out);
  endtask

  task automatic test_fwd();
    logic [1:0] exp;
    do_reset();
    regwriteM = 1; rdM = 5; regwriteW = 1; rdW = 5; rs1E = 5;
    @(negedge clk);
    exp = FWD ? 2'b10 : 2'b00;
    checks++;
    if (forward_aE !== exp) begin
      errors++; $display("FAIL fwd_m_over_w: got %b want %b", forward_aE, exp);
    end
    step();
    rdM = 0;
    @(negedge clk);
    exp = FWD ? 2'b01 : 2'b00;
    checks++;
    if (forward_aE !== exp) begin
      errors++; $display("FAIL fwd_w_only: got %b want %b", forward_aE, exp);
    end
    step();
    rdW = 0; rs1E = 0;
    @(negedge clk);
    checks++;
    if (forward_aE !== 2'b00) begin
      errors++; $display("FAIL fwd_x0: got %b want 00", forward_aE);
    end
    step();
    regwriteM = 1; rdM = 9; rdW = 9; rs2E = 9;
    @(negedge clk);
    exp = FWD ? 2'b10 : 2'b00;
    checks++;
    if (forward_bE !== exp) begin
      errors++; $display("FAIL fwd_b_m: got %b want %b", forward_bE, exp);
    end
    step();
    $display("test_fwd: last forward_bE=%b", forward_bE);
  endtask

  task automatic test_load_use();
    do_reset();
    result_srcE = 2'b01; regwriteE = 1; rdE = 7; rs2D = 7;
    @(negedge clk);
    checks++;
    if (dut_out[10:4] !== 7'b1100_010) begin
      errors++; $display("FAIL load_use_ctrl: got %b want 1100010", dut_out[10:4]);
    end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (stallF !== 1'b0 || stall_count !== 4'd1) begin
      errors++; $display("FAIL load_use_bubble: stallF=%b stall_count=%0d want 0/1", stallF, stall_count);
    end
    step();
    $display("test_load_use: stall_count=%0d", stall_count);
  endtask

  task automatic test_branch_lu();
    do_reset();
    result_srcE = 2'b01; regwriteE = 1; rdE = 7; rs2D = 7; pc_srcE = 1;
    @(negedge clk);
    checks++;
    if (dut_out[10:4] !== 7'b0000_110) begin
      errors++; $display("FAIL branch_over_lu: got %b want 0000110", dut_out[10:4]);
    end
    step();
    $display("test_branch_lu: ctrl=%b", dut_out[10:4]);
  endtask

  task automatic test_mem_wait();
    do_reset();
    memwriteM = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dut_out[10:4] !== 7'b1111_001) begin
        errors++; $display("FAIL mem_wait_freeze%0d: got %b want 1111001", i, dut_out[10:4]);
      end
      step();
    end
    dmem_ready = 1;
    @(negedge clk);
    checks++;
    if (dut_out[10:4] !== 7'b0000_000 || stall_count !== 4'd3) begin
      errors++; $display("FAIL mem_wait_release: ctrl=%b stall_count=%0d want 0000000/3", dut_out[10:4], stall_count);
    end
    step();
    idle();
    $display("test_mem_wait: stall_count=%0d", stall_count);
  endtask

  task automatic test_timeout();
    do_reset();
    memwriteM = 1; dmem_ready = 0;
    // One edge to enter the wait, then the fault lands on the 4th waiting cycle.
    for (int i = 1; i <= TMO + 1; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (mem_fault !== (i == TMO + 1)) begin
        errors++; $display("FAIL timeout_edge%0d: mem_fault=%b want %b", i, mem_fault, (i == TMO + 1));
      end
    end
    memwriteM = 0; dmem_ready = 1;
    step();
    @(negedge clk);
    checks++;
    if (mem_fault !== 1'b1 || stallF !== 1'b1) begin
      errors++; $display("FAIL fault_sticky: mem_fault=%b stallF=%b want 1/1", mem_fault, stallF);
    end
    rst = 1;
    step();
    rst = 0; memwriteM = 1; dmem_ready = 1;
    @(negedge clk);
    checks++;
    if (mem_fault !== 1'b0 || stallF !== 1'b0) begin
      errors++; $display("FAIL fault_reset: mem_fault=%b stallF=%b want 0/0", mem_fault, stallF);
    end
    step();
    idle();
    $display("test_timeout: mem_fault=%b", mem_fault);
  endtask

  task automatic test_raw();
    do_reset();
    regwriteM = 1; rdM = 3; rs1D = 3; rs1E = 3;
    @(negedge clk);
    checks++;
    if (stallD !== !FWD || flushE !== !FWD || forward_aE !== (FWD ? 2'b10 : 2'b00)) begin
      errors++; $display("FAIL raw_m: stallD=%b flushE=%b fwdA=%b want %b/%b/%b",
                         stallD, flushE, forward_aE, !FWD, !FWD, (FWD ? 2'b10 : 2'b00));
    end
    step();
    $display("test_raw: stallD=%b forward_aE=%b", stallD, forward_aE);
  endtask

  task automatic test_random();
    logic [10:0] e;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 39) == 0);
      rs1D        = 5'($urandom_range(0, 3));
      rs2D        = 5'($urandom_range(0, 3));
      rs1E        = 5'($urandom_range(0, 3));
      rs2E        = 5'($urandom_range(0, 3));
      rdE         = 5'($urandom_range(0, 3));
      rdM         = 5'($urandom_range(0, 3));
      rdW         = 5'($urandom_range(0, 3));
      regwriteE   = 1'($urandom_range(0, 1));
      regwriteM   = 1'($urandom_range(0, 1));
      regwriteW   = 1'($urandom_range(0, 1));
      result_srcE = 2'($urandom_range(0, 3));
      result_srcM = 2'($urandom_range(0, 3));
      memwriteM   = ($urandom_range(0, 3) == 0);
      pc_srcE     = ($urandom_range(0, 4) == 0);
      dmem_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      e = model_out();
      checks++;
      if (dut_out !== e) begin
        errors++; $display("FAIL rand_ctrl[%0d]: got %b want %b", n, dut_out, e);
      end
      checks++;
      if (mem_fault !== m_fault) begin
        errors++; $display("FAIL rand_fault[%0d]: got %b want %b", n, mem_fault, m_fault);
      end
      checks++;
      if (stall_count !== CNT_W'(m_cnt)) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, stall_count, m_cnt);
      end
      step();
    end
    idle();
    $display("test_random: 600 cycles, final stall_count=%0d", stall_count);
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    test_reset();
    test_fwd();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_raw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
